// File: rtl/bcd_xs3_sequencer.sv
// Streams a packed BCD word through a BCD-to-Excess-3 converter one digit at a time, LSD first.
// Optional: define XS3_ABORT_ON_ERR_EN to end the word after the first invalid digit is accepted.
//
// state  | meaning
// IDLE   | waiting for start; xs3_out and err hold the previous result
// EMIT   | presenting digit idx on the valid/ready handshake
// DONE   | one-cycle completion pulse
module bcd_xs3_sequencer #(
    parameter int DIGITS = 4,
    parameter int IDXW   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  digit_valid,
    output logic [3:0]            digit_out,
    output logic [IDXW-1:0]       digit_idx,
    output logic [4*DIGITS-1:0]   xs3_out,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] word_q;
    logic [4*DIGITS-1:0] xs3_q;
    logic [IDXW-1:0]     idx_q;
    logic                err_q;

    logic [3:0] cur_digit;
    logic [3:0] cur_xs3;
    logic       cur_bad;
    logic       last;
    logic       load;
    logic       accept;

    // The word shifts right on every accept, so the current digit is always the low nibble.
    assign cur_digit = word_q[3:0];
    assign cur_bad   = (cur_digit > 4'd9);
    assign cur_xs3   = cur_bad ? 4'd0 : cur_digit + 4'd3;
    assign last      = (idx_q == IDXW'(DIGITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        busy        = 1'b1;
        digit_valid = 1'b0;
        done        = 1'b0;
        load        = 1'b0;
        accept      = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    load    = 1'b1;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                digit_valid = 1'b1;
                if (out_ready) begin
                    accept = 1'b1;
                    if (last) begin
                        state_d = S_DONE;
                    end
`ifdef XS3_ABORT_ON_ERR_EN
                    else if (cur_bad) begin
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            xs3_q  <= '0;
            idx_q  <= '0;
            err_q  <= 1'b0;
        end else if (load) begin
            word_q <= bcd_in;
            xs3_q  <= '0;
            idx_q  <= '0;
            err_q  <= 1'b0;
        end else if (state_q == S_EMIT) begin
            if (cur_bad) begin
                err_q <= 1'b1;
            end
            if (accept) begin
                word_q <= word_q >> 4;
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        xs3_q[4*i +: 4] <= cur_xs3;
                    end
                end
                // Hold idx on the last digit so it never wraps past DIGITS-1.
                if (!last) begin
                    idx_q <= idx_q + IDXW'(1);
                end
            end
        end
    end

    assign digit_out = digit_valid ? cur_xs3 : 4'd0;
    assign digit_idx = idx_q;
    assign xs3_out   = xs3_q;
    assign err       = err_q | (digit_valid & cur_bad);

endmodule

// File: tb/tb_bcd_xs3_sequencer.sv
// Randomized bench for bcd_xs3_sequencer: per-digit arithmetic reference model, random stalls.
// Honors XS3_ABORT_ON_ERR_EN the same way the design does.
module tb_bcd_xs3_sequencer;
    localparam int DIGITS = 4;
    localparam int IDXW   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] bcd_in;
    logic        out_ready;
    logic        busy;
    logic        digit_valid;
    logic [3:0]  digit_out;
    logic [2:0]  digit_idx;
    logic [15:0] xs3_out;
    logic        done;
    logic        err;

    int n_chk  = 0;
    int n_fail = 0;

    bcd_xs3_sequencer #(.DIGITS(DIGITS), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in), .out_ready(out_ready),
        .busy(busy), .digit_valid(digit_valid), .digit_out(digit_out), .digit_idx(digit_idx),
        .xs3_out(xs3_out), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int xs3_of(input int d);
        return (d > 9) ? 0 : d + 3;
    endfunction

    // Convert one word; each digit is stalled for a random count in [smin, smax] cycles.
    task automatic run_word(input logic [15:0] w, input int smin, input int smax, input bit poke);
        int d;
        int stall;
        int xs3_exp;
        bit bad_seen;
        xs3_exp  = 0;
        bad_seen = 1'b0;
        start    = 1'b1;
        bcd_in   = w;
        @(posedge clk); #1;
        start = poke;
        if (poke) bcd_in = 16'h0000;
        for (int k = 0; k < DIGITS; k++) begin
            d        = int'((w >> (4 * k)) & 16'hF);
            bad_seen = bad_seen | (d > 9);
            stall    = int'($urandom_range(smax, smin));
            for (int s = 0; s <= stall; s++) begin
                out_ready = (s == stall);
                chk("valid", 32'(digit_valid), 32'd1);
                chk("busy", 32'(busy), 32'd1);
                chk("digit", 32'(digit_out), 32'(xs3_of(d)));
                chk("idx", 32'(digit_idx), 32'(k));
                chk("err", 32'(err), 32'(bad_seen));
                chk("done_early", 32'(done), 32'd0);
                chk("xs3_partial", 32'(xs3_out), 32'(xs3_exp));
                @(posedge clk); #1;
            end
            out_ready = 1'b0;
            xs3_exp   = xs3_exp | (xs3_of(d) << (4 * k));
`ifdef XS3_ABORT_ON_ERR_EN
            if (d > 9) break;
`endif
        end
        chk("done", 32'(done), 32'd1);
        chk("valid_done", 32'(digit_valid), 32'd0);
        chk("xs3_done", 32'(xs3_out), 32'(xs3_exp));
        chk("err_done", 32'(err), 32'(bad_seen));
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_idle", 32'(busy), 32'd0);
        chk("done_idle", 32'(done), 32'd0);
        chk("xs3_hold", 32'(xs3_out), 32'(xs3_exp));
        chk("err_hold", 32'(err), 32'(bad_seen));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(digit_valid), 32'd0);
        chk("rst_digit", 32'(digit_out), 32'd0);
        chk("rst_idx", 32'(digit_idx), 32'd0);
        chk("rst_xs3", 32'(xs3_out), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
    endtask

    initial begin
        logic [15:0] w;
        int nib;
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        bcd_in    = 16'h0000;
        #2;
        chk_reset_outputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs();

        run_word(16'h1234, 0, 0, 1'b0);
        run_word(16'h0909, 0, 0, 1'b0);
        run_word(16'h12A4, 0, 0, 1'b0);
        run_word(16'h9999, 3, 3, 1'b0);
        run_word(16'h5678, 0, 2, 1'b1);

        // Abort mid-word by reset while digit 2 is presented.
        start  = 1'b1;
        bcd_in = 16'h1234;
        @(posedge clk); #1;
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        chk("idx_before_rst", 32'(digit_idx), 32'd2);
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs();
        run_word(16'h0000, 0, 0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            w = 16'h0000;
            for (int k = 0; k < DIGITS; k++) begin
                nib = ($urandom_range(9, 0) < 2) ? int'($urandom_range(15, 10))
                                                 : int'($urandom_range(9, 0));
                w = w | (16'(nib) << (4 * k));
            end
            run_word(w, 0, 2, 1'($urandom_range(1, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
